// File: rtl/instruction_fetch_unit.sv
// Fetch-side requester for the instruction cache: PC generation,
// redirect/drain handling and a 2-entry instruction buffer to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] PC,
  output logic        PC_VALID,
  output logic        INSTRUCTION_CACHE_STALL,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTRUCTION_CACHE_READY,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        DECODE_STALL,
  output logic [31:0] IF_INSTRUCTION,
  output logic [31:0] IF_PC,
  output logic        IF_VALID
);

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    START,
    REQUEST,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] redirect_pc;
  logic [31:0] target;
  logic [1:0]  count;
  logic [31:0] head_pc;
  logic [31:0] head_ins;
  logic [31:0] tail_pc;
  logic [31:0] tail_ins;
  logic        full;
  logic        accept;
  logic        pop;
  logic        push;

  assign target   = {BRANCH_TARGET[31:2], 2'b00};
  assign full     = (count == 2'd2);
  assign IF_VALID = (count != 2'd0);
  assign IF_PC    = head_pc;
  assign IF_INSTRUCTION = head_ins;

  // The buffer is always empty in DRAIN, so stall is never raised there.
  assign INSTRUCTION_CACHE_STALL =
    PC_VALID & full & DECODE_STALL;

  assign accept = PC_VALID
                & INSTRUCTION_CACHE_READY
                & ~INSTRUCTION_CACHE_STALL;
  assign pop    = IF_VALID & ~DECODE_STALL;
  assign push   = (state == REQUEST)
                & accept
                & ~BRANCH_TAKEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= START;
      PC_VALID    <= LOW;
      PC          <= RESET_VECTOR;
      redirect_pc <= 32'h0;
    end else begin
      unique case (state)
        START: begin
          state    <= REQUEST;
          PC_VALID <= HIGH;
          if (BRANCH_TAKEN)
            PC <= target;
        end
        REQUEST: begin
          if (BRANCH_TAKEN && accept) begin
            PC <= target;
          end else if (BRANCH_TAKEN) begin
            redirect_pc <= target;
            state       <= DRAIN;
          end else if (accept) begin
            PC <= PC + 32'd4;
          end
        end
        DRAIN: begin
          if (INSTRUCTION_CACHE_READY) begin
            PC    <= BRANCH_TAKEN ? target : redirect_pc;
            state <= REQUEST;
          end else if (BRANCH_TAKEN) begin
            redirect_pc <= target;
          end
        end
        default: begin
          state    <= START;
          PC_VALID <= LOW;
        end
      endcase
    end
  end

  // Head/tail shift buffer: head is what decode sees.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count    <= 2'd0;
      head_pc  <= 32'h0;
      head_ins <= 32'h0;
      tail_pc  <= 32'h0;
      tail_ins <= 32'h0;
    end else if (BRANCH_TAKEN) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc  <= PC;
            head_ins <= INSTRUCTION;
          end else begin
            tail_pc  <= PC;
            tail_ins <= INSTRUCTION;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc  <= tail_pc;
          head_ins <= tail_ins;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc  <= PC;
            head_ins <= INSTRUCTION;
          end else begin
            head_pc  <= tail_pc;
            head_ins <= tail_ins;
            tail_pc  <= PC;
            tail_ins <= INSTRUCTION;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure,
// redirects (accept, drain, double, wrap) and reset mid-operation.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        ic_stall;
  logic [31:0] instruction;
  logic        ic_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        dec_stall;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        if_valid;

  int checks;
  int failures;

  instruction_fetch_unit #(
    .RESET_VECTOR(32'h0000_0100)
  ) dut (
    .CLK                    (clk),
    .RST                    (rst),
    .PC                     (pc),
    .PC_VALID               (pc_valid),
    .INSTRUCTION_CACHE_STALL(ic_stall),
    .INSTRUCTION            (instruction),
    .INSTRUCTION_CACHE_READY(ic_ready),
    .BRANCH_TAKEN           (br_taken),
    .BRANCH_TARGET          (br_target),
    .DECODE_STALL           (dec_stall),
    .IF_INSTRUCTION         (if_ins),
    .IF_PC                  (if_pc),
    .IF_VALID               (if_valid)
  );

  // Cache model: the word at address A is ~A.
  assign instruction = ~pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    ic_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    dec_stall = 1'b0;
    tick();
    tick();

    check("rst_pc",       pc,       32'h100);
    check("rst_pc_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_stall",    {31'b0, ic_stall}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_ins",   if_ins,   32'h0);
    check("rst_if_pc",    if_pc,    32'h0);

    // Release reset, cache always ready.
    rst      = 1'b0;
    ic_ready = 1'b1;
    settle();
    check("start_pc_valid", {31'b0, pc_valid}, 32'd0);
    tick();
    check("req_pc",       pc,       32'h100);
    check("req_pc_valid", {31'b0, pc_valid}, 32'd1);
    check("req_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("s1_pc",       pc,     32'h104);
    check("s1_if_pc",    if_pc,  32'h100);
    check("s1_if_ins",   if_ins, ~32'h100);
    check("s1_if_valid", {31'b0, if_valid}, 32'd1);

    // Backpressure for 4 edges.
    dec_stall = 1'b1;
    tick();
    check("bp_pc",    pc,    32'h108);
    check("bp_if_pc", if_pc, 32'h100);
    check("bp_stall", {31'b0, ic_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_pc",    pc,    32'h108);
      check("bp_hold_if_pc", if_pc, 32'h100);
      check("bp_hold_stall", {31'b0, ic_stall}, 32'd1);
    end
    dec_stall = 1'b0;
    settle();
    check("bp_release_stall", {31'b0, ic_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_drain_if_pc", if_pc, 32'h104 + 32'(4 * i));
      check("bp_drain_if_ins", if_ins,
            ~(32'h104 + 32'(4 * i)));
      check("bp_drain_pc", pc, 32'h10C + 32'(4 * i));
      check("bp_drain_valid", {31'b0, if_valid}, 32'd1);
    end

    // Redirect with accept in the same cycle.
    br_taken  = 1'b1;
    br_target = 32'h2003;
    tick();
    br_taken = 1'b0;
    check("ra_pc",       pc, 32'h2000);
    check("ra_pc_valid", {31'b0, pc_valid}, 32'd1);
    check("ra_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("ra_next_if_pc", if_pc, 32'h2000);
    check("ra_next_pc",    pc,    32'h2004);

    // Move to 0x40, then redirect during a miss.
    br_taken  = 1'b1;
    br_target = 32'h40;
    tick();
    check("rm_pc40", pc, 32'h40);
    ic_ready  = 1'b0;
    br_target = 32'h800;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rm_hold_pc",    pc, 32'h40);
      check("rm_hold_valid", {31'b0, pc_valid}, 32'd1);
      check("rm_hold_ifv",   {31'b0, if_valid}, 32'd0);
      tick();
    end
    check("rm_hold_pc3", pc, 32'h40);
    ic_ready = 1'b1;
    settle();
    check("rm_drain_stall", {31'b0, ic_stall}, 32'd0);
    tick();
    check("rm_target_pc", pc, 32'h800);
    check("rm_discard",   {31'b0, if_valid}, 32'd0);
    tick();
    check("rm_first_if_pc", if_pc, 32'h800);
    check("rm_first_pc",    pc,    32'h804);

    // Double redirect during DRAIN, then wrap.
    ic_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h900;
    tick();
    check("dr_hold_pc", pc, 32'h804);
    br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    check("dr_hold_pc2", pc, 32'h804);
    ic_ready = 1'b1;
    tick();
    check("dr_target_pc", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc",     pc,     32'h0);
    check("wrap_if_pc",  if_pc,  32'hFFFF_FFFC);
    check("wrap_if_ins", if_ins, 32'h3);
    tick();
    check("wrap_pc4",   pc,    32'h4);
    check("wrap_if_pc0", if_pc, 32'h0);

    // New redirect arriving together with the drained READY wins.
    ic_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h500;
    tick();
    ic_ready  = 1'b1;
    br_target = 32'h600;
    tick();
    br_taken = 1'b0;
    check("dr_same_pc",  pc, 32'h600);
    check("dr_same_ifv", {31'b0, if_valid}, 32'd0);

    // Reset during DRAIN.
    ic_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h700;
    tick();
    br_taken = 1'b0;
    rst      = 1'b1;
    ic_ready = 1'b1;
    tick();
    check("rd_pc",       pc, 32'h100);
    check("rd_pc_valid", {31'b0, pc_valid}, 32'd0);
    check("rd_if_valid", {31'b0, if_valid}, 32'd0);

    // Reset with a full buffer.
    rst       = 1'b0;
    dec_stall = 1'b1;
    tick();
    tick();
    tick();
    check("rf_full_stall", {31'b0, ic_stall}, 32'd1);
    rst = 1'b1;
    tick();
    check("rf_pc",       pc, 32'h100);
    check("rf_if_valid", {31'b0, if_valid}, 32'd0);
    check("rf_if_pc",    if_pc, 32'h0);
    check("rf_stall",    {31'b0, ic_stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Requester side of the instruction-cache interface: generates the fetch PC, presents it to the instruction cache, and collects returned instructions. Returned instructions go into a 2-entry buffer that feeds decode. It also handles branch redirects, including draining a cache request that is in flight when the redirect arrives. It sits between the PC/branch logic of the core and the instruction cache.

## Interface
- HIGH, 1'b1, logic-high constant
- LOW, 1'b0, logic-low constant
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- PC  out  32  fetch address presented to cache
- PC_VALID  out  1  fetch request valid
- INSTRUCTION_CACHE_STALL  out  1  fetch unit cannot accept a response this cycle
- INSTRUCTION  in  32  instruction returned by cache for PC
- INSTRUCTION_CACHE_READY  in  1  INSTRUCTION valid for current PC this cycle
- BRANCH_TAKEN  in  1  redirect request, single-cycle pulse
- BRANCH_TARGET  in  32  redirect address (bits [1:0] ignored, forced to 0)
- DECODE_STALL  in  1  decode will not consume buffer head this cycle
- IF_INSTRUCTION  out  32  buffer head instruction
- IF_PC  out  32  PC of buffer head
- IF_VALID  out  1  buffer head valid

## Operation
- **Handshake rules**
  - accept = PC_VALID & INSTRUCTION_CACHE_READY & ~INSTRUCTION_CACHE_STALL.
  - PC stays stable while PC_VALID is high and no accept has occurred.
- **States**
  - START: PC_VALID=0. Always goes to REQUEST on the next edge.
  - REQUEST: PC_VALID=1.
    - On accept: push {PC, INSTRUCTION} into the buffer; PC <= PC+4, wrapping mod 2^32 (32'hFFFF_FFFC+4 = 0).
    - BRANCH_TAKEN with accept in the same cycle: drop the response (no push); PC <= {BRANCH_TARGET[31:2],2'b00}; stay in REQUEST.
    - BRANCH_TAKEN without accept: latch the target in REDIRECT_PC; go to DRAIN.
  - DRAIN: PC_VALID=1 with the old PC held; INSTRUCTION_CACHE_STALL=0.
    - On INSTRUCTION_CACHE_READY: discard the response; PC <= REDIRECT_PC; go to REQUEST.
    - A new BRANCH_TAKEN while in DRAIN overwrites REDIRECT_PC. If READY arrives in the same cycle, the new target is used.
- **Buffer**
  - 2-entry FIFO with a count of 0..2.
  - pop = IF_VALID & ~DECODE_STALL.
  - Push and pop in the same cycle are allowed when count is 1 or 2; the count is unchanged.
  - INSTRUCTION_CACHE_STALL = PC_VALID & (count==2) & DECODE_STALL. When count is 2 and decode pops, a push is still accepted.
  - IF_VALID = (count!=0). IF_INSTRUCTION and IF_PC show the head entry.
- **Flush**
  - BRANCH_TAKEN at an edge sets count to 0, regardless of any pop in that cycle.
  - A head popped in the redirect cycle is delivered to decode; decode is responsible for killing it.
- **Reset**
  - RST has priority over everything.
  - Clears state to START, the buffer, and REDIRECT_PC.

## Timing
- **Reset values:** PC=RESET_VECTOR, PC_VALID=0, INSTRUCTION_CACHE_STALL=0, IF_VALID=0, IF_INSTRUCTION=0, IF_PC=0.
- **Start-up:** in the first cycle after RST deasserts, PC_VALID=0. PC_VALID=1 from the second cycle.
- **Latency:** an instruction accepted at edge N appears at IF_* after edge N (registered), with IF_VALID=1 in cycle N+1.
- **Throughput:** one instruction per cycle when READY is held high and DECODE_STALL=0.
- **Redirect with no stall:** a redirect at edge N presents the target on PC in cycle N+1.
- **Redirect with DRAIN:** the target is presented in the cycle after the drained READY.
- **Stall output:** INSTRUCTION_CACHE_STALL is combinational from count and DECODE_STALL. The cache must hold its response while it is high.
- **Reset mid-operation:** RST during DRAIN or with a full buffer gives the reset values on the next cycle. No pending response is pushed.

## Test plan
- **Reset then streaming.** RESET_VECTOR=32'h100, READY=1 constantly, DECODE_STALL=0, RST released. Required: PC_VALID low for 1 cycle, then PC = 100, 104, 108, …; IF_PC follows one cycle behind with IF_VALID=1 continuously.
- **Backpressure.** DECODE_STALL=1 for 4 cycles during streaming. Required: the buffer fills to 2 (IF_PC=100 held, 104 queued); INSTRUCTION_CACHE_STALL=1 and PC held at 108; after release, 104 then 108 are delivered in order with no loss or duplication.
- **Redirect with accept.** BRANCH_TAKEN=1, BRANCH_TARGET=32'h2003 in a cycle where READY=1. Required: that response is dropped, IF_VALID=0 next cycle, PC=32'h2000 next cycle.
- **Redirect during miss.** READY=0 at PC=32'h40, BRANCH_TAKEN with target 32'h800, READY held low for 3 cycles then pulsed. Required: PC stays 40 with PC_VALID=1 through DRAIN; the response is discarded (IF_VALID stays 0); PC=32'h800 the next cycle.
- **Double redirect and wrap.** A second BRANCH_TAKEN (target 32'hFFFF_FFFC) during DRAIN. Required: fetch resumes at FFFF_FFFC, then 0000_0000.
- **Reset mid-DRAIN.** RST during DRAIN. Required: next cycle has PC=RESET_VECTOR, PC_VALID=0, IF_VALID=0.
